alu_issue_wb: RTL
=================

Name: alu_issue_wb

Overview:
- Single-issue operand-fetch, issue and writeback stage wrapped around the 16-bit ALU.
- Accepts an instruction word on a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's opcode/ar_flag/src1/src2/out_en inputs, captures the ALU's out/flags, writes the result to rd and latches the flags.
- Also takes a load-writeback port from the memory stage.

Parameters:
- DATA_W, 16: datapath width; must match the ALU.
- NREGS, 8: register count. r0 reads as zero; writes to r0 are discarded.
- AW, 3: register index width, log2(NREGS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high iff state==IDLE
- instr  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5] ar, [4] imm, [3:0] rs2 index ([2:0] used) or imm4
- ld_we  in  1  load writeback strobe; honoured only in IDLE
- ld_addr  in  AW  load destination register
- ld_data  in  DATA_W  load data
- alu_opcode  out  4  to ALU opcode
- alu_ar  out  1  to ALU ar_flag
- alu_src1  out  DATA_W  to ALU src1
- alu_src2  out  DATA_W  to ALU src2
- alu_out_en  out  1  to ALU out_en
- alu_out  in  DATA_W  from ALU out
- alu_flags  in  4  from ALU flags, {O,C,N,Z}
- flags_q  out  4  architectural flags
- done  out  1  one-cycle pulse, writeback complete
- err  out  1  one-cycle pulse, instruction rejected
- busy  out  1  state!=IDLE

Behaviour:
- Reset values:
  - All registers = 0.
  - State IDLE.
  - alu_opcode/alu_ar/alu_src1/alu_src2 = 0, alu_out_en = 0.
  - flags_q = 0, done = 0, err = 0.
- Reset asserted mid-operation aborts with no register write, clears all of the above, and returns to IDLE next edge.
- FSM: IDLE -> ISSUE -> EXEC -> IDLE.
- IDLE:
  - Accept on instr_valid && instr_ready at edge E0.
  - Legal ops are 3..11. Ops 0-2 and 12-15 are illegal: err pulses the cycle after E0, state stays IDLE, no ALU activity.
  - Legal op: latch rd, and register alu_opcode=op, alu_ar=ar, alu_src1=R[rs1], alu_src2=imm ? zero-extended imm4 : R[rs2[2:0]].
  - Move to ISSUE.
- Operand read bypass: if ld_we is asserted at E0 and ld_addr matches a source index (and is nonzero), ld_data is forwarded. The load write also commits at E0.
- ISSUE: ALU inputs stable for one full cycle; the ALU samples them at the edge ending ISSUE. alu_out_en = 0.
- EXEC:
  - alu_out_en = 1 for exactly this cycle; the ALU updates out/flags at this cycle's negedge.
  - At the edge ending EXEC (E2): R[rd] <= alu_out (unless rd==0), flags_q <= alu_flags, alu_out_en <= 0, state <= IDLE.
  - done pulses during the cycle after E2.
- Latency: accept to register write is 2 edges (E0 to E2). Throughput is one instruction per 3 cycles. instr_ready is next high in the cycle after E2.
- ld_we outside IDLE is ignored.
- Back-to-back dependent instructions need no bypass: the write at E2 precedes the next accept.
- alu_src outputs hold their values after EXEC until the next accept.

Optional Feature:
- Macro DIV0_TRAP_EN.
- Defined: an op 6 (divide) whose resolved src2 == 0 at accept is rejected like an illegal op. err pulses, no ALU issue, no write, flags_q unchanged.
- Undefined: it is issued normally and the result is whatever the ALU produces.

Test Plan:
- Reset, then ld R1=0x0005 and R2=0x0003; issue op3 rd=3 rs1=1 rs2=2 -> alu_out_en high only in the EXEC cycle; R3=0x0008 at E2; done the cycle after; flags_q=0000.
- R1=0x0003, op4 rs2=R1 rs1=R1 rd=4 -> R4=0x0000, flags_q[0]=1; then op4 with imm=1, imm4=4, rs1=R1 -> R4=0xFFFF, N=1.
- instr op=0xC with instr_valid held -> err pulse one cycle, busy stays 0, no register or flags change; next legal op is accepted the following cycle.
- ld_we R5=0x1234 in the same cycle as accept of op7 rs1=5 imm=1 imm4=0xF -> alu_src1=0x1234 (bypass); R6=0x0004.
- rd=0 with op3 -> R0 still reads 0. Assert rst during EXEC -> no write, busy=0, flags_q=0 next cycle.
- op6 src2=R0: with DIV0_TRAP_EN -> err, alu_out_en never asserted; without it -> issue proceeds and done pulses.

Source files
------------

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: single-issue operand fetch / issue / writeback stage for the
// 16-bit ALU. Three-state FSM (IDLE -> ISSUE -> EXEC), internal register file
// with r0 hard-wired to zero, load-writeback port with read bypass at accept.
// Optional build macro DIV0_TRAP_EN: reject divide (op 6) whose resolved src2
// is zero at accept, reporting it through err like an illegal opcode.
module alu_issue_wb #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [3:0]        alu_opcode,
  output logic              alu_ar,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_out_en,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output logic              done,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [AW-1:0]     rd_q;

  // instruction fields
  logic [3:0]        op;
  logic [AW-1:0]     rd, rs1, rs2;
  logic              ar, imm;
  logic [3:0]        imm4;
  logic              accept, legal, trap, issue_ok;
  logic [DATA_W-1:0] src1_val, src2_val, rs2_val;

  assign op   = instr[15:12];
  assign rd   = AW'(instr[11:9]);
  assign rs1  = AW'(instr[8:6]);
  assign ar   = instr[5];
  assign imm  = instr[4];
  assign imm4 = instr[3:0];
  assign rs2  = AW'(instr[2:0]);

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Operand read with load bypass: a load landing on the accept edge is
  // forwarded so the instruction sees the value being committed alongside it.
  always_comb begin
    src1_val = '0;
    rs2_val  = '0;
    if (rs1 != '0)
      src1_val = (ld_we && ld_addr == rs1) ? ld_data : regs[rs1];
    if (rs2 != '0)
      rs2_val = (ld_we && ld_addr == rs2) ? ld_data : regs[rs2];
    src2_val = imm ? DATA_W'(imm4) : rs2_val;
  end

  // Accept / legality decode and next-state selection
  always_comb begin
    state_nxt = state;
    accept    = instr_valid && (state == IDLE);
    legal     = (op >= 4'd3) && (op <= 4'd11);
`ifdef DIV0_TRAP_EN
    trap      = (op == 4'd6) && (src2_val == '0);
`else
    trap      = 1'b0;
`endif
    issue_ok  = accept && legal && !trap;
    case (state)
      IDLE:    if (issue_ok) state_nxt = ISSUE;
      ISSUE:   state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ALU drive, flags and status pulses; ALU inputs hold until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_ar     <= 1'b0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      alu_out_en <= 1'b0;
      flags_q    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      rd_q       <= '0;
    end else begin
      done <= 1'b0;
      err  <= accept && !issue_ok;
      if (issue_ok) begin
        alu_opcode <= op;
        alu_ar     <= ar;
        alu_src1   <= src1_val;
        alu_src2   <= src2_val;
        rd_q       <= rd;
      end
      alu_out_en <= (state == ISSUE);
      if (state == EXEC) begin
        flags_q <= alu_flags;
        done    <= 1'b1;
      end
    end
  end

  // Register file: loads commit only in IDLE, ALU results at the end of EXEC;
  // the two never coincide so one write port per state suffices.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == IDLE) begin
      if (ld_we && ld_addr != '0) regs[ld_addr] <= ld_data;
    end else if (state == EXEC) begin
      if (rd_q != '0) regs[rd_q] <= alu_out;
    end
  end

endmodule
